// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the SPI memory master.
// Holds the command opcodes and the transaction state enum used by the top level.
package spi_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: divides clk into SCLK phases and shifts one byte MSB first.
// Strobes look one cycle ahead: they flag that the coming clk edge is a falling/rising SCLK edge.
module spi_shift_engine #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       byte_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             phase_end;
  logic             bit_done;

  always_comb begin
    phase_end = run && (div_q == DIV_W'(CLK_DIV - 1));
    bit_done  = phase_end && sclk_q;
    rx_done   = phase_end && !sclk_q && (bit_cnt_q == 3'd7);
    byte_done = bit_done && (bit_cnt_q == 3'd7);
    rx_byte   = {rx_q[6:0], miso};

    div_d     = div_q;
    sclk_d    = sclk_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;

    if (run) div_d = phase_end ? '0 : div_q + DIV_W'(1);
    if (phase_end && !sclk_q) begin
      sclk_d = 1'b1;
      rx_d   = rx_byte;
    end
    if (bit_done) begin
      sclk_d    = 1'b0;
      tx_d      = {tx_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // A load always lands on a byte boundary, so it also restarts the phase counters.
    if (load) begin
      tx_d      = load_byte;
      div_d     = '0;
      sclk_d    = 1'b0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      sclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else begin
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
    end
  end

  assign sclk = sclk_q;
  assign mosi = tx_q[7];

endmodule

// File: rtl/spi_mem_master.sv
// SPI master for serial ROM/RAM: opcode, address, then a burst of data bytes.
// Owns the transaction FSM, byte counting and chip selects; bit timing lives in spi_shift_engine.
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int NUM_CS    = 2,
  parameter int CLK_DIV   = 1,
  parameter int MAX_BURST = 4,
  localparam int SEL_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LEN_W    = $clog2(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              write,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        wdata,
  output logic              wdata_ack,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int CNT_W      = (LEN_W > 2) ? LEN_W : 2;

  spi_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wdata_ack_q, wdata_ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;

  logic              eng_run;
  logic              load;
  logic [7:0]        load_byte;
  logic [7:0]        rx_byte;
  logic              rx_done;
  logic              byte_done;

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    len_d         = len_q;
    byte_cnt_d    = byte_cnt_q;
    cs_n_d        = cs_n_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    wdata_ack_d   = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    load          = 1'b0;
    load_byte     = 8'h00;
    eng_run       = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

    case (state_q)
      ST_IDLE: begin
        if (start && (32'(cs_sel) < NUM_CS)) begin
          state_d   = ST_CMD;
          write_d   = write;
          addr_d    = addr;
          len_d     = len;
          busy_d    = 1'b1;
          cs_n_d    = ~(NUM_CS'(1) << cs_sel);
          load      = 1'b1;
          load_byte = write ? OP_WRITE : OP_READ;
        end
      end
      ST_CMD: begin
        if (byte_done) begin
          state_d    = ST_ADDR;
          byte_cnt_d = CNT_W'(ADDR_BYTES - 1);
          load       = 1'b1;
          load_byte  = addr_q[ADDR_W-1 -: 8];
          addr_d     = addr_q << 8;
        end
      end
      ST_ADDR: begin
        if (byte_done) begin
          load = 1'b1;
          if (byte_cnt_q == '0) begin
            state_d     = ST_DATA;
            byte_cnt_d  = CNT_W'(len_q);
            load_byte   = write_q ? wdata : 8'h00;
            wdata_ack_d = write_q;
          end else begin
            byte_cnt_d = byte_cnt_q - CNT_W'(1);
            load_byte  = addr_q[ADDR_W-1 -: 8];
            addr_d     = addr_q << 8;
          end
        end
      end
      ST_DATA: begin
        if (rx_done && !write_q) begin
          rdata_d       = rx_byte;
          rdata_valid_d = 1'b1;
        end
        if (byte_done) begin
          load = 1'b1;
          if (byte_cnt_q == '0) begin
            state_d = ST_HOLD;
          end else begin
            byte_cnt_d  = byte_cnt_q - CNT_W'(1);
            load_byte   = write_q ? wdata : 8'h00;
            wdata_ack_d = write_q;
          end
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        cs_n_d  = '1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      byte_cnt_q    <= '0;
      cs_n_q        <= '1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wdata_ack_q   <= 1'b0;
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      byte_cnt_q    <= byte_cnt_d;
      cs_n_q        <= cs_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wdata_ack_q   <= wdata_ack_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (eng_run),
    .load     (load),
    .load_byte(load_byte),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi),
    .rx_byte  (rx_byte),
    .rx_done  (rx_done),
    .byte_done(byte_done)
  );

  assign cs_n        = cs_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wdata_ack   = wdata_ack_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
